// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised multi-port register file with bypass and busy scoreboard
module reg_file_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NR*ADDR_W-1:0] rd_addr,
  output logic [NR*DATA_W-1:0] rd_data,
  output logic [NR-1:0]        rd_rdy,
  input  logic [NW-1:0]        wr_en,
  input  logic [NW*ADDR_W-1:0] wr_addr,
  input  logic [NW*DATA_W-1:0] wr_data,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 busy_any
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_nxt;

  // Storage update; ports are visited in ascending order so the highest-index port wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && !(HAS_ZERO && (wr_addr[w*ADDR_W +: ADDR_W] == '0))) begin
          mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard next state: writes clear, then a reserve re-sets so a new producer stays pending
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NW; w++) begin
      if (wr_en[w]) begin
        busy_nxt[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (rsv_en) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
    if (HAS_ZERO) begin
      busy_nxt[0] = 1'b0;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign busy_any = |busy;

  for (genvar r = 0; r < NR; r++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[r*ADDR_W +: ADDR_W];

    // Read mux: stored value, overridden by the highest-index matching write, overridden by r0
    always_comb begin
      rd_data[r*DATA_W +: DATA_W] = mem[addr];
      rd_rdy[r] = ~busy[addr];
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == addr)) begin
          rd_data[r*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
          rd_rdy[r] = 1'b1;
        end
      end
      if (HAS_ZERO && (addr == '0)) begin
        rd_data[r*DATA_W +: DATA_W] = '0;
        rd_rdy[r] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp
module tb_reg_file_mp;

  logic        clk;
  logic        rst;
  logic [7:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_addr;

  logic [31:0] rd_data_a, rd_data_z;
  logic [1:0]  rd_rdy_a, rd_rdy_z;
  logic [15:0] busy_a, busy_z;
  logic        busy_any_a, busy_any_z;

  int checks;
  int failures;

  reg_file_mp #(.DATA_W(16), .ADDR_W(4), .NR(2), .NW(2), .ZERO_REG(0)) u_dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_rdy(rd_rdy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy(busy_a), .busy_any(busy_any_a)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(4), .NR(2), .NW(2), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_rdy(rd_rdy_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy(busy_z), .busy_any(busy_any_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input logic [1:0] en, input logic [3:0] a0, input logic [15:0] d0,
                        input logic [3:0] a1, input logic [15:0] d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic idle();
    set_wr(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
    rsv_en   = 1'b0;
    rsv_addr = 4'd0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_rd(4'd0, 4'd0);
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // reset state on every address, both ports, both variants
    for (int a = 0; a < 16; a++) begin
      set_rd(4'(a), 4'(15 - a));
      #1;
      check("rst_data", rd_data_a, 32'h0);
      check("rst_rdy", {30'd0, rd_rdy_a}, 32'h3);
      check("rst_data_z", rd_data_z, 32'h0);
      check("rst_rdy_z", {30'd0, rd_rdy_z}, 32'h3);
    end
    check("rst_busy", {16'd0, busy_a}, 32'h0);
    check("rst_busy_any", {31'd0, busy_any_a}, 32'h0);

    // write r1 via port 0: bypass in the write cycle, stored afterwards
    set_rd(4'd1, 4'd1);
    set_wr(2'b01, 4'd1, 16'hA5A5, 4'd0, 16'h0);
    #1;
    check("byp_r1", rd_data_a, 32'hA5A5_A5A5);
    check("byp_r1_rdy", {30'd0, rd_rdy_a}, 32'h3);
    tick();
    idle();
    #1;
    check("st_r1", rd_data_a, 32'hA5A5_A5A5);
    check("st_r1_rdy", {30'd0, rd_rdy_a}, 32'h3);

    // both ports write r3: port 1 wins for bypass and storage
    set_rd(4'd3, 4'd1);
    set_wr(2'b11, 4'd3, 16'h1111, 4'd3, 16'h2222);
    #1;
    check("byp_r3_prio", rd_data_a, 32'hA5A5_2222);
    tick();
    idle();
    #1;
    check("st_r3_prio", rd_data_a, 32'hA5A5_2222);

    // two ports to different addresses both land
    set_wr(2'b11, 4'd8, 16'h8888, 4'd9, 16'h9999);
    tick();
    idle();
    set_rd(4'd8, 4'd9);
    #1;
    check("dual_wr", rd_data_a, 32'h9999_8888);

    // reserve r5: not visible in its own cycle
    set_rd(4'd5, 4'd1);
    rsv_en   = 1'b1;
    rsv_addr = 4'd5;
    #1;
    check("rsv_same_cyc_rdy", {30'd0, rd_rdy_a}, 32'h3);
    tick();
    idle();
    #1;
    check("rsv_busy", {16'd0, busy_a}, 32'h0020);
    check("rsv_busy_any", {31'd0, busy_any_a}, 32'h1);
    check("rsv_rdy", {30'd0, rd_rdy_a}, 32'h2);
    // producer writes r5: bypass makes it ready now, busy clears next cycle
    set_wr(2'b01, 4'd5, 16'h3C3C, 4'd0, 16'h0);
    #1;
    check("wb_byp_data", rd_data_a, 32'hA5A5_3C3C);
    check("wb_byp_rdy", {30'd0, rd_rdy_a}, 32'h3);
    tick();
    idle();
    #1;
    check("wb_busy", {16'd0, busy_a}, 32'h0);
    check("wb_busy_any", {31'd0, busy_any_a}, 32'h0);
    check("wb_rdy", {30'd0, rd_rdy_a}, 32'h3);

    // reserve and write r7 in one cycle: data updated, still busy
    set_rd(4'd7, 4'd7);
    rsv_en   = 1'b1;
    rsv_addr = 4'd7;
    set_wr(2'b10, 4'd0, 16'h0, 4'd7, 16'h0F0F);
    tick();
    idle();
    #1;
    check("rw_r7_data", rd_data_a, 32'h0F0F_0F0F);
    check("rw_r7_rdy", {30'd0, rd_rdy_a}, 32'h0);
    check("rw_r7_busy", {16'd0, busy_a}, 32'h0080);

    // r0 write and reserve: hardwired in the zero variant, ordinary otherwise
    set_rd(4'd0, 4'd7);
    rsv_en   = 1'b1;
    rsv_addr = 4'd0;
    set_wr(2'b01, 4'd0, 16'hFFFF, 4'd0, 16'h0);
    #1;
    check("z_byp_r0", rd_data_z, 32'h0F0F_0000);
    check("z_byp_r0_rdy", {30'd0, rd_rdy_z[0]}, 32'h1);
    tick();
    idle();
    #1;
    check("z_r0_data", rd_data_z, 32'h0F0F_0000);
    check("z_r0_rdy", {30'd0, rd_rdy_z}, 32'h1);
    check("z_busy", {16'd0, busy_z}, 32'h0080);
    check("a_r0_data", rd_data_a, 32'h0F0F_FFFF);
    check("a_r0_rdy", {30'd0, rd_rdy_a}, 32'h0);
    check("a_busy", {16'd0, busy_a}, 32'h0081);

    // r2 busy holding 0x1234, then reset with a write and reserve pending
    set_rd(4'd2, 4'd4);
    rsv_en   = 1'b1;
    rsv_addr = 4'd2;
    set_wr(2'b01, 4'd2, 16'h1234, 4'd0, 16'h0);
    tick();
    idle();
    #1;
    check("pre_rst_r2", rd_data_a, 32'h0000_1234);
    check("pre_rst_busy", {16'd0, busy_a}, 32'h0085);
    rst      = 1'b1;
    rsv_en   = 1'b1;
    rsv_addr = 4'd4;
    set_wr(2'b01, 4'd2, 16'h5555, 4'd0, 16'h0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("post_rst_data", rd_data_a, 32'h0);
    check("post_rst_rdy", {30'd0, rd_rdy_a}, 32'h3);
    check("post_rst_busy", {16'd0, busy_a}, 32'h0);
    check("post_rst_busy_any", {31'd0, busy_any_a}, 32'h0);
    check("post_rst_busy_z", {16'd0, busy_z}, 32'h0);
    set_rd(4'd1, 4'd7);
    #1;
    check("post_rst_r1_r7", rd_data_a, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the datapath, succeeding the fixed 16x16, two-read/one-write file. Supports configurable width, depth, read-port count and write-port count. Adds same-cycle write-to-read bypass with defined write priority, an optional hardwired zero register, and a per-register busy scoreboard, so the issue stage can tell whether an operand is ready. Sits between decode/issue (read and reserve side) and writeback (write side).

## Interface

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; depth = 2^ADDR_W
- NR, 2, number of read ports (1..4)
- NW, 1, number of write ports (1..4)
- ZERO_REG, 0, when 1 register 0 always reads 0 and is never busy

Ports:
- clk, input, 1, single clock; all state updates on rising edge
- rst, input, 1, synchronous, active-high reset
- rd_addr, input, NR*ADDR_W, read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data, output, NR*DATA_W, read data, combinational; port i at [i*DATA_W +: DATA_W]
- rd_rdy, output, NR, port i operand valid (not busy, or bypassed this cycle)
- wr_en, input, NW, per-port write enable
- wr_addr, input, NW*ADDR_W, write addresses
- wr_data, input, NW*DATA_W, write data
- rsv_en, input, 1, reserve request; marks rsv_addr busy
- rsv_addr, input, ADDR_W, register to reserve
- busy, output, 2^ADDR_W, scoreboard bit per register (registered)
- busy_any, output, 1, OR of busy

## Operation

- Storage: 2^ADDR_W registers of DATA_W bits, flop-based; reset clears all to 0.
- Writes, at the rising edge: each port with wr_en=1 writes wr_data to wr_addr.
  - Several ports to the same address: the highest-index port wins.
  - ZERO_REG=1: writes to address 0 are ignored.
- Reads are combinational. For each read port, the data is chosen in this order:
  - ZERO_REG=1 and address 0: data 0, rdy=1.
  - Else, if any enabled write port targets the same address this cycle: data from the highest-index such port (bypass), rdy=1.
  - Else: stored value, rdy = ~busy[addr].
- Scoreboard:
  - rsv_en=1 sets busy[rsv_addr] at the next edge.
  - A write to an address clears its busy bit at the next edge.
  - Reserve and write to the same address in one cycle: busy ends at 1. Data is updated and the new producer is pending.
  - ZERO_REG=1: busy[0] is held at 0 and reserves of address 0 are ignored.
  - Reserving an already-busy register leaves it busy. There is no count; a single write clears it.
- Reads never alter state. Any number of read ports may target the same address.

## Timing

- Reset: on a rising edge with rst=1, all registers become 0, busy becomes 0 and busy_any becomes 0.
  - rst overrides wr_en and rsv_en in the same cycle; writes and reserves are dropped.
  - After reset, rd_data = 0 and rd_rdy = all ones for any address, unless bypass applies.
- Read latency 0: rd_data and rd_rdy follow rd_addr, wr_* and busy combinationally.
- Write latency 1: the stored value is visible without bypass from the cycle after the edge.
- Reserve latency 1: busy is visible on rd_rdy from the cycle after rsv_en.
  - A reserve does not lower rd_rdy in its own cycle.
- Reset mid-operation: all pending reservations are lost and all data is zeroed.
- No handshake back-pressure: writes and reserves are always accepted.

## Test plan

- Reset, then read all addresses on all ports -> rd_data = 0x0000, rd_rdy = 1, busy = 0.
- Write 0xA5A5 to r1 via port 0, next cycle read r1 on both ports -> both 0xA5A5, rdy = 1. During the write cycle, reading r1 -> 0xA5A5 via bypass.
- NW=2: port 0 writes r3=0x1111 and port 1 writes r3=0x2222 in the same cycle -> bypass read is 0x2222 and the stored value is 0x2222.
- Reserve r5 -> next cycle busy[5]=1, busy_any=1, rd_rdy=0 on r5. Write r5=0x3C3C -> same cycle rdy=1 with data 0x3C3C; next cycle busy[5]=0.
- In the same cycle, reserve r7 and write r7=0x0F0F -> next cycle r7 reads 0x0F0F with rdy=0 and busy[7]=1.
- ZERO_REG=1: write r0=0xFFFF and reserve r0 -> r0 reads 0x0000, rdy=1, busy[0]=0. Separately, assert rst while r2 is busy and holds 0x1234 -> next cycle r2 = 0 and busy = 0.
